// File: rtl/fetch_redirect_pkg.sv
// Shared LC-3b front-end types: word type, fetch FSM states and redirect target selects.
package fetch_redirect_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } lc3b_fetch_state;

  typedef logic [1:0] lc3b_pcmux_sel;

  localparam lc3b_pcmux_sel PCMUX_SEQ  = 2'b00;
  localparam lc3b_pcmux_sel PCMUX_BR   = 2'b01;
  localparam lc3b_pcmux_sel PCMUX_JMP  = 2'b10;
  localparam lc3b_pcmux_sel PCMUX_TRAP = 2'b11;

  localparam lc3b_word PC_INCR = 16'd2;

  // Instructions are word aligned, so every PC load drops bit 0.
  function automatic lc3b_word align_pc(input lc3b_word addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_redirect_if.sv
// Fetch-stage signal bundle: instruction memory, decode handoff and writeback redirect.
interface fetch_redirect_if
  import fetch_redirect_pkg::*;
  ;

  logic          imem_read;
  lc3b_word      imem_address;
  logic          imem_resp;
  lc3b_word      imem_rdata;

  logic          if_valid;
  lc3b_word      if_ir;
  lc3b_word      if_pc;
  logic          id_ready;

  logic          wb_flush;
  lc3b_pcmux_sel wb_pcmux_sel;
  lc3b_word      wb_pc;
  lc3b_word      wb_br_addr;
  lc3b_word      wb_jmp_addr;
  lc3b_word      wb_trap_addr;

  modport master (
    output imem_read, imem_address, if_valid, if_ir, if_pc,
    input  imem_resp, imem_rdata, id_ready,
    input  wb_flush, wb_pcmux_sel, wb_pc, wb_br_addr, wb_jmp_addr, wb_trap_addr
  );

  modport slave (
    input  imem_read, imem_address, if_valid, if_ir, if_pc,
    output imem_resp, imem_rdata, id_ready,
    output wb_flush, wb_pcmux_sel, wb_pc, wb_br_addr, wb_jmp_addr, wb_trap_addr
  );

endinterface

// File: rtl/fetch_redirect_target_mux.sv
// Redirect target select: sequential (wb_pc+2), branch, register jump or trap vector.
module redirect_target_mux
  import fetch_redirect_pkg::*;
(
  input  lc3b_pcmux_sel sel,
  input  lc3b_word      wb_pc,
  input  lc3b_word      br_addr,
  input  lc3b_word      jmp_addr,
  input  lc3b_word      trap_addr,
  output lc3b_word      target
);

  always_comb begin
    target = wb_pc + PC_INCR;
    unique case (sel)
      PCMUX_SEQ:  target = wb_pc + PC_INCR;
      PCMUX_BR:   target = br_addr;
      PCMUX_JMP:  target = jmp_addr;
      PCMUX_TRAP: target = trap_addr;
      default:    target = wb_pc + PC_INCR;
    endcase
  end

endmodule

// File: rtl/fetch_redirect.sv
// LC-3b fetch front end: owns the PC, runs the imem handshake and holds one instruction for decode.
module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input logic              clk,
  input logic              rst_n,
  fetch_redirect_if.master bus
);

  lc3b_fetch_state state_q, state_d;
  lc3b_word        pc_q, pc_d;
  lc3b_word        req_addr_q, req_addr_d;
  logic            imem_read_q, imem_read_d;
  logic            if_valid_q, if_valid_d;
  lc3b_word        if_ir_q, if_ir_d;
  lc3b_word        if_pc_q, if_pc_d;

  lc3b_word        target;
  logic            resp_v;

  redirect_target_mux u_target_mux (
    .sel       (bus.wb_pcmux_sel),
    .wb_pc     (bus.wb_pc),
    .br_addr   (bus.wb_br_addr),
    .jmp_addr  (bus.wb_jmp_addr),
    .trap_addr (bus.wb_trap_addr),
    .target    (target)
  );

  // A response only counts while a request is actually outstanding.
  assign resp_v = bus.imem_resp & imem_read_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_ir_d    = if_ir_q;
    if_pc_d    = if_pc_q;

    unique case (state_q)
      FETCH: begin
        if (bus.wb_flush) begin
          pc_d = target;
          if (imem_read_q && !resp_v) state_d = DRAIN;
        end else if (resp_v) begin
          if_ir_d    = bus.imem_rdata;
          if_pc_d    = pc_q + PC_INCR;
          if_valid_d = 1'b1;
          pc_d       = pc_q + PC_INCR;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (bus.wb_flush) begin
          if_valid_d = 1'b0;
          pc_d       = target;
          state_d    = FETCH;
        end else if (bus.id_ready) begin
          if_valid_d = 1'b0;
          state_d    = FETCH;
        end
      end
      DRAIN: begin
        if (bus.wb_flush) pc_d = target;
        if (resp_v) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    pc_d        = align_pc(pc_d);
    imem_read_d = (state_d != HOLD);

    // The address latches only when a fresh request begins, so it stays put while draining.
    req_addr_d = req_addr_q;
    if (state_d == FETCH && (!imem_read_q || resp_v)) req_addr_d = pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= align_pc(RESET_PC);
      req_addr_q  <= align_pc(RESET_PC);
      imem_read_q <= 1'b0;
      if_valid_q  <= 1'b0;
      if_ir_q     <= '0;
      if_pc_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      imem_read_q <= imem_read_d;
      if_valid_q  <= if_valid_d;
      if_ir_q     <= if_ir_d;
      if_pc_q     <= if_pc_d;
    end
  end

  assign bus.imem_read    = imem_read_q;
  assign bus.imem_address = req_addr_q;
  assign bus.if_valid     = if_valid_q;
  assign bus.if_ir        = if_ir_q;
  assign bus.if_pc        = if_pc_q;

endmodule

// File: tb/tb_fetch_redirect.sv
// Randomized scoreboard bench for fetch_redirect: memory/decode/writeback stimulus versus an instruction-stream model.
module tb_fetch_redirect;

  localparam logic [15:0] RESET_PC = 16'h0000;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ir;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  fetch_redirect_if bus ();

  fetch_redirect #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int accepted = 0;

  // Reference-model state
  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  logic [15:0] exp_addr;
  logic [15:0] model_req_addr;
  bit          in_req;
  bit          stale;
  int          lat;
  bit          stim_en = 0;
  bit          quiet = 0;

  // Monitor state
  bit          mon_en = 0;
  bit          mon_in_req;
  logic [15:0] mon_addr;
  bit          prev_hold;
  logic [15:0] prev_ir, prev_pc;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'(a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] model_target(input logic [1:0] sel, input logic [15:0] pc,
                                               input logic [15:0] br, input logic [15:0] jmp,
                                               input logic [15:0] trap);
    logic [15:0] t;
    if (sel == 2'd0)      t = pc + 16'd2;
    else if (sel == 2'd1) t = br;
    else if (sel == 2'd2) t = jmp;
    else                  t = trap;
    return t & 16'hFFFE;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic drive_idle();
    bus.imem_resp    = 1'b0;
    bus.imem_rdata   = 16'h0000;
    bus.id_ready     = 1'b0;
    bus.wb_flush     = 1'b0;
    bus.wb_pcmux_sel = 2'b00;
    bus.wb_pc        = 16'h0000;
    bus.wb_br_addr   = 16'h0000;
    bus.wb_jmp_addr  = 16'h0000;
    bus.wb_trap_addr = 16'h0000;
  endtask

  task automatic model_reset();
    exp_q.delete();
    addr_q.delete();
    exp_addr   = RESET_PC & 16'hFFFE;
    in_req     = 0;
    stale      = 0;
    lat        = 0;
    mon_in_req = 0;
    prev_hold  = 0;
  endtask

  // One cycle of stimulus plus model update; runs just after each rising edge.
  task automatic step();
    logic        flush, resp;
    logic [15:0] tgt;
    if (bus.imem_read && !in_req) begin
      in_req         = 1;
      stale          = 0;
      lat            = $urandom_range(0, 3);
      model_req_addr = exp_addr;
      addr_q.push_back(exp_addr);
    end
    flush = !quiet && ($urandom_range(0, 5) == 0);
    bus.wb_flush     = flush;
    bus.wb_pcmux_sel = 2'($urandom_range(0, 3));
    bus.wb_pc        = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
    bus.wb_br_addr   = 16'($urandom);
    bus.wb_jmp_addr  = 16'($urandom);
    bus.wb_trap_addr = 16'($urandom);
    bus.id_ready     = quiet ? 1'b1 : ($urandom_range(0, 9) < 6);
    tgt = model_target(bus.wb_pcmux_sel, bus.wb_pc, bus.wb_br_addr, bus.wb_jmp_addr, bus.wb_trap_addr);

    resp = 1'b0;
    if (in_req && bus.imem_read) begin
      if (lat == 0) resp = 1'b1;
      else lat--;
    end
    bus.imem_resp  = resp;
    bus.imem_rdata = resp ? mem_word(bus.imem_address) : 16'($urandom);

    if (flush && in_req) stale = 1;
    if (resp) begin
      if (!stale) begin
        exp_q.push_back('{pc: model_req_addr + 16'd2, ir: mem_word(model_req_addr), cyc: cyc});
        exp_addr = model_req_addr + 16'd2;
      end
      in_req = 0;
    end
    if (flush) exp_addr = tgt;
  endtask

  initial begin : stim
    forever begin
      @(posedge clk);
      #2;
      if (stim_en) step();
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [15:0] a;
    if (mon_en && rst_n) begin
      if (mon_in_req && !bus.imem_read) chk("imem_read_held", bus.imem_read, 16'd1);
      if (bus.imem_read && !mon_in_req) begin
        if (addr_q.size() == 0) chk("req_expected", 16'd1, 16'd0);
        else begin
          a = addr_q.pop_front();
          chk("req_addr", bus.imem_address, a);
        end
        mon_in_req = 1;
        mon_addr   = bus.imem_address;
      end else if (bus.imem_read) begin
        chk("addr_stable", bus.imem_address, mon_addr);
      end
      if (!bus.imem_read || bus.imem_resp) mon_in_req = 0;

      if (bus.if_valid) begin
        if (prev_hold) begin
          chk("hold_ir", bus.if_ir, prev_ir);
          chk("hold_pc", bus.if_pc, prev_pc);
        end
        if (exp_q.size() == 0) chk("unexpected_valid", bus.if_valid, 16'd0);
        else if (bus.id_ready || bus.wb_flush) begin
          e = exp_q.pop_front();
          chk("if_pc", bus.if_pc, e.pc);
          chk("if_ir", bus.if_ir, e.ir);
          if (!bus.wb_flush) accepted++;
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("if_valid_latency", bus.if_valid, 16'd1);
      end
      prev_hold = bus.if_valid && !bus.id_ready && !bus.wb_flush;
      prev_ir   = bus.if_ir;
      prev_pc   = bus.if_pc;
    end
  end

  initial begin : main
    bit found;
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_imem_read", bus.imem_read, 16'd0);
    chk("rst_if_valid", bus.if_valid, 16'd0);
    chk("rst_if_ir", bus.if_ir, 16'h0000);
    chk("rst_if_pc", bus.if_pc, 16'h0000);
    #1 rst_n = 1'b1;
    stim_en = 1;
    mon_en  = 1;

    repeat (1500) @(posedge clk);

    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #3;
      if (bus.imem_read) found = 1;
    end
    chk("mid_fetch_found", 16'(found), 16'd1);
    stim_en = 0;
    mon_en  = 0;
    rst_n   = 1'b0;
    #1;
    chk("async_rst_imem_read", bus.imem_read, 16'd0);
    chk("async_rst_if_valid", bus.if_valid, 16'd0);
    chk("async_rst_if_ir", bus.if_ir, 16'h0000);
    chk("async_rst_if_pc", bus.if_pc, 16'h0000);
    drive_idle();
    repeat (3) @(negedge clk);
    model_reset();
    #1 rst_n = 1'b1;
    stim_en = 1;
    mon_en  = 1;

    repeat (600) @(posedge clk);
    quiet = 1;
    repeat (20) @(posedge clk);
    #3;
    chk("progress", 16'(accepted > 100), 16'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
